kim_stream_fifo: RTL

- Synchronous valid/ready stream FIFO. It is the upstream producer that feeds a skid-buffered pipeline stage.
- Input side is a valid/ready sink; output side is a fully registered valid/ready source whose m_valid and m_data come straight from flops.
- Absorbs bursts of up to DEPTH+1 words and carries backpressure upstream without combinational paths from input ports to output ports.

---
 rtl/kim_stream_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/kim_stream_fifo.sv
// kim_stream_fifo: valid/ready stream FIFO with a DEPTH-entry RAM and a
// registered output stage. It holds up to DEPTH+1 words in total.
//
// Handshake: a word moves on a rising edge exactly when valid and ready are
// both high on that edge. s_ready comes only from the registered pointers
// (and rst), so it never depends on m_ready. m_valid and m_data come straight
// from flops. Once m_valid is high, m_data stays stable and m_valid stays
// high until a word is accepted with m_valid & m_ready.
module kim_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pointer difference that means the RAM is full. The wrap bit is set and
    // the index bits are zero.
    localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic [ADDR_WIDTH:0]   w_ram_used;
    logic                  w_ram_full;
    logic                  w_ram_empty;
    logic                  w_wr_en;
    logic                  w_load;
    logic                  w_unload;

    // Occupancy is decoded from the registered pointers. The extra MSB tells full apart from empty.
    assign w_ram_used  = r_wr_ptr - r_rd_ptr;
    assign w_ram_full  = (w_ram_used == RAM_DEPTH);
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);

    assign s_ready  = ~w_ram_full & ~rst;
    assign w_wr_en  = s_valid & s_ready;
    // The output register loads from RAM whenever it is free or is being
    // emptied this edge. Only words already in RAM can load, so there is no bypass.
    assign w_load   = ~w_ram_empty & (~r_m_valid | m_ready);
    assign w_unload = r_m_valid & m_ready & ~w_load;

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign count   = w_ram_used + {{ADDR_WIDTH{1'b0}}, r_m_valid};
    assign empty   = (count == '0);

    // RAM write port. Contents are not reset. Only entries written after reset can ever be read out.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_data;
        end
    end

    // Pointers and the output register. Write and load update independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_m_data  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_m_valid <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end else if (w_unload) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule
